// File: rtl/cursor_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cursor_mode_ctrl_if
// Description : Signal bundle between the mouse front-end / game logic and
//               the cursor mode controller. The controller takes the slave
//               view; whoever drives the raw inputs takes the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cursor_mode_ctrl_if;
  logic [11:0] xpos_in;
  logic [11:0] ypos_in;
  logic        left;
  logic        right;
  logic        vblnk;
  logic        game_active;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        select_mode;
  logic        fire;
  logic [11:0] fire_x;
  logic [11:0] fire_y;
  logic        reloading;
  logic [7:0]  reload_cnt;

  modport master (
    output xpos_in, ypos_in, left, right, vblnk, game_active,
    input  xpos, ypos, select_mode, fire, fire_x, fire_y, reloading, reload_cnt
  );

  modport slave (
    input  xpos_in, ypos_in, left, right, vblnk, game_active,
    output xpos, ypos, select_mode, fire, fire_x, fire_y, reloading, reload_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cursor_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cursor_mode_ctrl
// Description : Cursor overlay sequencer. Latches clamped pointer coordinates
//               once per frame, selects arrow/scope cursor, and issues
//               one-shot fire pulses followed by a frame-counted lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_mode_ctrl #(
  parameter int H_MAX         = 799,
  parameter int V_MAX         = 599,
  parameter int AIM_X_LIMIT   = 600,
  parameter int RELOAD_FRAMES = 60
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cursor_mode_ctrl_if.slave bus
);

  localparam logic [11:0] c_H_MAX   = 12'(H_MAX);
  localparam logic [11:0] c_V_MAX   = 12'(V_MAX);
  localparam logic [11:0] c_AIM_LIM = 12'(AIM_X_LIMIT);
  localparam logic [7:0]  c_RELOAD  = 8'(RELOAD_FRAMES);

  typedef enum logic [1:0] {
    ST_POINTER = 2'd0,
    ST_AIM     = 2'd1,
    ST_FIRE    = 2'd2,
    ST_RELOAD  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_left_meta, r_left_s, r_left_s_d;
  logic        r_right_meta, r_right_s;
  logic        r_vblnk_d;
  logic [11:0] r_xpos, r_ypos;
  logic        r_select_mode;
  logic        r_fire;
  logic [11:0] r_fire_x, r_fire_y;
  logic        r_reloading;
  logic [7:0]  r_reload_cnt;

  logic        w_left_rise;
  logic        w_frame_start;
  logic        w_aim_ok;
  logic [11:0] w_xclamp, w_yclamp;

  // Edge detects and aim qualification; aim uses the coordinate already
  // on screen, not the one about to be latched this cycle.
  assign w_left_rise   = r_left_s & ~r_left_s_d;
  assign w_frame_start = bus.vblnk & ~r_vblnk_d;
  assign w_aim_ok      = r_right_s & bus.game_active & (r_xpos < c_AIM_LIM);
  assign w_xclamp      = (bus.xpos_in > c_H_MAX) ? c_H_MAX : bus.xpos_in;
  assign w_yclamp      = (bus.ypos_in > c_V_MAX) ? c_V_MAX : bus.ypos_in;

  // Two-flop synchronizers for the mouse buttons plus vblank edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_left_meta  <= 1'b0;
      r_left_s     <= 1'b0;
      r_left_s_d   <= 1'b0;
      r_right_meta <= 1'b0;
      r_right_s    <= 1'b0;
      r_vblnk_d    <= 1'b0;
    end else begin
      r_left_meta  <= bus.left;
      r_left_s     <= r_left_meta;
      r_left_s_d   <= r_left_s;
      r_right_meta <= bus.right;
      r_right_s    <= r_right_meta;
      r_vblnk_d    <= bus.vblnk;
    end
  end

  // Pointer coordinates change only at frame start so the overlay never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xpos <= 12'd0;
      r_ypos <= 12'd0;
    end else if (w_frame_start) begin
      r_xpos <= w_xclamp;
      r_ypos <= w_yclamp;
    end
  end

  // Mode/fire sequencer with registered outputs; leaving the match forces
  // the arrow cursor and clears any lockout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_POINTER;
      r_select_mode <= 1'b0;
      r_fire        <= 1'b0;
      r_fire_x      <= 12'd0;
      r_fire_y      <= 12'd0;
      r_reloading   <= 1'b0;
      r_reload_cnt  <= 8'd0;
    end else begin
      r_fire <= 1'b0;
      if (!bus.game_active) begin
        r_state       <= ST_POINTER;
        r_select_mode <= 1'b0;
        r_reloading   <= 1'b0;
        r_reload_cnt  <= 8'd0;
      end else begin
        case (r_state)
          ST_POINTER: begin
            r_select_mode <= w_aim_ok;
            if (w_aim_ok) r_state <= ST_AIM;
          end
          ST_AIM: begin
            if (!w_aim_ok) begin
              r_state       <= ST_POINTER;
              r_select_mode <= 1'b0;
            end else if (w_left_rise) begin
              r_state      <= ST_FIRE;
              r_fire       <= 1'b1;
              r_fire_x     <= r_xpos;
              r_fire_y     <= r_ypos;
              r_reload_cnt <= c_RELOAD;
            end
          end
          ST_FIRE: begin
            r_state     <= ST_RELOAD;
            r_reloading <= 1'b1;
          end
          ST_RELOAD: begin
            r_select_mode <= w_aim_ok;
            if (r_reload_cnt == 8'd0) begin
              r_state     <= w_aim_ok ? ST_AIM : ST_POINTER;
              r_reloading <= 1'b0;
            end else if (w_frame_start) begin
              r_reload_cnt <= r_reload_cnt - 8'd1;
            end
          end
          default: r_state <= ST_POINTER;
        endcase
      end
    end
  end

  assign bus.xpos        = r_xpos;
  assign bus.ypos        = r_ypos;
  assign bus.select_mode = r_select_mode;
  assign bus.fire        = r_fire;
  assign bus.fire_x      = r_fire_x;
  assign bus.fire_y      = r_fire_y;
  assign bus.reloading   = r_reloading;
  assign bus.reload_cnt  = r_reload_cnt;

endmodule
`default_nettype wire
